// File: rtl/hci_core_mux_tracked_if.sv
// HCI core channel bundle: one initiator/target request-response link.
// Master drives the request fields, slave returns grant and response.
interface hci_core_intf #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int BW = 8,
   parameter int WW = 32,
   parameter int OW = 1
) ();
   logic              req;
   logic              gnt;
   logic [AW-1:0]     add;
   logic              wen;
   logic [DW-1:0]     data;
   logic [DW/BW-1:0]  be;
   logic [WW-1:0]     boffs;
   logic              lrdy;
   logic [DW-1:0]     r_data;
   logic              r_valid;
   logic [OW-1:0]     r_opc;

   modport master (
      output req, add, wen, data, be, boffs, lrdy,
      input  gnt, r_data, r_valid, r_opc
   );

   modport slave (
      input  req, add, wen, data, be, boffs, lrdy,
      output gnt, r_data, r_valid, r_opc
   );
endinterface

// File: rtl/hci_core_mux_tracked.sv
// Funnels NB_IN_CHAN HCI initiator channels onto NB_OUT_CHAN target channels.
// Input j is served by output j % NB_OUT_CHAN. Each output arbitrates its group
// round-robin with a starvation override, and remembers the winner of every
// handshake in a small FIFO so in-order responses go back to the right input.
module hci_core_mux_tracked #(
   parameter int NB_IN_CHAN  = 4,
   parameter int NB_OUT_CHAN = 2,
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int BW          = 8,
   parameter int WW          = 32,
   parameter int OW          = 1,
   parameter int RESP_DEPTH  = 4,
   parameter int MAX_WAIT    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   hci_core_intf.slave  in  [NB_IN_CHAN],
   hci_core_intf.master out [NB_OUT_CHAN],
   output logic        err_o
);

   localparam int BEW = DW / BW;
   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam int FAW = $clog2(RESP_DEPTH);
   localparam int CW  = FAW + 1;

   // Flattened view of the input channels.
   logic [NB_IN_CHAN-1:0]  in_req, in_wen, in_lrdy, in_gnt, in_rvalid, in_urgent;
   logic [AW-1:0]          in_add   [NB_IN_CHAN];
   logic [DW-1:0]          in_data  [NB_IN_CHAN];
   logic [BEW-1:0]         in_be    [NB_IN_CHAN];
   logic [WW-1:0]          in_boffs [NB_IN_CHAN];
   logic [DW-1:0]          in_rdata [NB_IN_CHAN];
   logic [OW-1:0]          in_ropc  [NB_IN_CHAN];
   logic [NB_OUT_CHAN-1:0] err_hit;
   logic                   err_q, err_d;

   // ---------------------------------------------------------------------
   // Per-input plumbing and wait counter
   // ---------------------------------------------------------------------
   for (genvar j = 0; j < NB_IN_CHAN; j++) begin : g_in
      logic [WCW-1:0] wait_q, wait_d;

      assign in_req[j]    = in[j].req;
      assign in_add[j]    = in[j].add;
      assign in_wen[j]    = in[j].wen;
      assign in_data[j]   = in[j].data;
      assign in_be[j]     = in[j].be;
      assign in_boffs[j]  = in[j].boffs;
      assign in_lrdy[j]   = in[j].lrdy;
      assign in[j].gnt     = in_gnt[j];
      assign in[j].r_valid = in_rvalid[j];
      assign in[j].r_data  = in_rdata[j];
      assign in[j].r_opc   = in_ropc[j];

      // A requester is urgent once it has been refused MAX_WAIT times in a row.
      assign in_urgent[j] = in_req[j] && (wait_q == WCW'(MAX_WAIT));

      // Wait counter: count refused request cycles, saturating, clear on grant or idle.
      // NOTE: every combinational output gets a default first so no latch is inferred.
      always_comb begin
         wait_d = wait_q;
         if (!in_req[j] || in_gnt[j])
            wait_d = '0;
         else if (wait_q != WCW'(MAX_WAIT))
            wait_d = wait_q + WCW'(1);
      end

      // Wait counter register.
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      always_ff @(posedge clk_i) begin
         if (rst_i || clear_i) wait_q <= '0;
         else                  wait_q <= wait_d;
      end
   end

   // ---------------------------------------------------------------------
   // Per-output arbiter, request mux, response-routing FIFO
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NB_OUT_CHAN; i++) begin : g_out
      localparam int G  = (NB_IN_CHAN - i + NB_OUT_CHAN - 1) / NB_OUT_CHAN;
      localparam int PW = (G > 1) ? $clog2(G) : 1;

      logic [G-1:0]   req_l, urg_l, gnt_l, rv_l;
      logic [AW-1:0]  add_l   [G];
      logic [DW-1:0]  data_l  [G];
      logic [BEW-1:0] be_l    [G];
      logic [WW-1:0]  boffs_l [G];
      logic [G-1:0]   wen_l, lrdy_l;

      logic           o_gnt, o_rvalid, o_req, o_wen, o_lrdy;
      logic [DW-1:0]  o_rdata, o_data;
      logic [OW-1:0]  o_ropc;
      logic [AW-1:0]  o_add;
      logic [BEW-1:0] o_be;
      logic [WW-1:0]  o_boffs;

      logic [PW-1:0]  ptr_q, ptr_d;
      logic [PW-1:0]  mem_q [RESP_DEPTH];
      logic [FAW-1:0] wr_q, wr_d, rd_q, rd_d;
      logic [CW-1:0]  cnt_q, cnt_d;
      logic           full, empty, push, pop, found;
      logic [PW-1:0]  head;
      int             win;

      // Group lanes: local index k is global input k*NB_OUT_CHAN + i.
      for (genvar k = 0; k < G; k++) begin : g_lane
         localparam int J = k * NB_OUT_CHAN + i;
         assign req_l[k]   = in_req[J];
         assign urg_l[k]   = in_urgent[J];
         assign add_l[k]   = in_add[J];
         assign wen_l[k]   = in_wen[J];
         assign data_l[k]  = in_data[J];
         assign be_l[k]    = in_be[J];
         assign boffs_l[k] = in_boffs[J];
         assign lrdy_l[k]  = in_lrdy[J];
         assign in_gnt[J]    = gnt_l[k];
         assign in_rvalid[J] = rv_l[k];
         assign in_rdata[J]  = rv_l[k] ? o_rdata : '0;
         assign in_ropc[J]   = rv_l[k] ? o_ropc  : '0;
      end

      assign o_gnt    = out[i].gnt;
      assign o_rvalid = out[i].r_valid;
      assign o_rdata  = out[i].r_data;
      assign o_ropc   = out[i].r_opc;

      assign out[i].req   = o_req;
      assign out[i].add   = o_add;
      assign out[i].wen   = o_wen;
      assign out[i].data  = o_data;
      assign out[i].be    = o_be;
      assign out[i].boffs = o_boffs;
      assign out[i].lrdy  = o_lrdy;

      assign full    = (cnt_q == CW'(RESP_DEPTH));
      assign empty   = (cnt_q == '0);
      assign head    = mem_q[rd_q];
      assign push    = o_req && o_gnt;
      assign pop     = o_rvalid && !empty;
      assign err_hit[i] = o_rvalid && empty;

      // Winner: lowest urgent requester, else first requester at or after ptr, wrapping.
      always_comb begin
         win   = 0;
         found = 1'b0;
         for (int k = 0; k < G; k++)
            if (!found && urg_l[k]) begin win = k; found = 1'b1; end
         for (int k = 0; k < G; k++)
            if (!found && req_l[k] && k >= int'(ptr_q)) begin win = k; found = 1'b1; end
         for (int k = 0; k < G; k++)
            if (!found && req_l[k]) begin win = k; found = 1'b1; end
      end

      // Forward the winner's request; a full tracking FIFO blocks the whole group.
      always_comb begin
         o_req   = found && !full;
         gnt_l   = '0;
         o_add   = '0;
         o_wen   = 1'b0;
         o_data  = '0;
         o_be    = '0;
         o_boffs = '0;
         o_lrdy  = 1'b0;
         for (int k = 0; k < G; k++) begin
            if (found && k == win) begin
               gnt_l[k] = o_gnt && !full;
               o_add    = add_l[k];
               o_wen    = wen_l[k];
               o_data   = data_l[k];
               o_be     = be_l[k];
               o_boffs  = boffs_l[k];
               o_lrdy   = lrdy_l[k];
            end
         end
      end

      // Route a response to the input recorded at the FIFO head.
      always_comb begin
         rv_l = '0;
         for (int k = 0; k < G; k++)
            if (pop && int'(head) == k) rv_l[k] = 1'b1;
      end

      // Pointer and FIFO bookkeeping for the next cycle.
      always_comb begin
         ptr_d = ptr_q;
         wr_d  = wr_q;
         rd_d  = rd_q;
         cnt_d = cnt_q;
         if (push) begin
            ptr_d = (win == G - 1) ? '0 : PW'(win + 1);
            wr_d  = wr_q + FAW'(1);
         end
         if (pop) rd_d = rd_q + FAW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      // Pointer and FIFO control registers.
      always_ff @(posedge clk_i) begin
         if (rst_i || clear_i) begin
            ptr_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            ptr_q <= ptr_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      // Winner ID storage.
      // NOTE: storage is not reset; only entries between rd_q and wr_q are ever read.
      always_ff @(posedge clk_i) begin
         if (push) mem_q[wr_q] <= PW'(win);
      end
   end

   // Sticky error: a response arrived with nothing outstanding on that output.
   always_comb begin
      err_d = err_q | (|err_hit);
   end

   // Error flag register.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) err_q <= 1'b0;
      else                  err_q <= err_d;
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_hci_core_mux_tracked.sv
// Directed bench for hci_core_mux_tracked: two instances, a 4->2 mux with
// two-deep tracking and a 5->2 mux with MAX_WAIT=2.
module tb_hci_core_mux_tracked;

   logic clk = 1'b0;
   logic rst, clear_a, clear_b, err_a, err_b;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // ---------------- instance A: 4 in, 2 out, RESP_DEPTH 2 ----------------
   hci_core_intf a_in  [4] ();
   hci_core_intf a_out [2] ();
   logic [3:0]  a_req, a_gnt, a_rv;
   logic [31:0] a_rdata [4];
   logic        a_ropc  [4];
   logic [1:0]  a_ognt, a_orv, a_oreq;
   logic [31:0] a_ordata [2];
   logic [31:0] a_oadd   [2];

   for (genvar g = 0; g < 4; g++) begin : g_a_in
      assign a_in[g].req   = a_req[g];
      assign a_in[g].add   = 32'((g + 1) * 256);
      assign a_in[g].wen   = 1'b0;
      assign a_in[g].data  = 32'(g);
      assign a_in[g].be    = '1;
      assign a_in[g].boffs = '0;
      assign a_in[g].lrdy  = 1'b1;
      assign a_gnt[g]   = a_in[g].gnt;
      assign a_rv[g]    = a_in[g].r_valid;
      assign a_rdata[g] = a_in[g].r_data;
      assign a_ropc[g]  = a_in[g].r_opc;
   end
   for (genvar g = 0; g < 2; g++) begin : g_a_out
      assign a_out[g].gnt     = a_ognt[g];
      assign a_out[g].r_valid = a_orv[g];
      assign a_out[g].r_data  = a_ordata[g];
      assign a_out[g].r_opc   = 1'b1;
      assign a_oreq[g] = a_out[g].req;
      assign a_oadd[g] = a_out[g].add;
   end

   hci_core_mux_tracked #(.NB_IN_CHAN(4), .NB_OUT_CHAN(2), .RESP_DEPTH(2), .MAX_WAIT(8)) dut_a (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .in(a_in), .out(a_out), .err_o(err_a)
   );

   // ---------------- instance B: 5 in, 2 out, MAX_WAIT 2 ----------------
   hci_core_intf b_in  [5] ();
   hci_core_intf b_out [2] ();
   logic [4:0]  b_req, b_gnt, b_rv;
   logic [1:0]  b_ognt, b_orv, b_oreq;
   logic [31:0] b_oadd [2];

   for (genvar g = 0; g < 5; g++) begin : g_b_in
      assign b_in[g].req   = b_req[g];
      assign b_in[g].add   = 32'((g + 1) * 256);
      assign b_in[g].wen   = 1'b1;
      assign b_in[g].data  = '0;
      assign b_in[g].be    = '1;
      assign b_in[g].boffs = '0;
      assign b_in[g].lrdy  = 1'b1;
      assign b_gnt[g] = b_in[g].gnt;
      assign b_rv[g]  = b_in[g].r_valid;
   end
   for (genvar g = 0; g < 2; g++) begin : g_b_out
      assign b_out[g].gnt     = b_ognt[g];
      assign b_out[g].r_valid = b_orv[g];
      assign b_out[g].r_data  = 32'hCAFE0000 + 32'(g);
      assign b_out[g].r_opc   = 1'b0;
      assign b_oreq[g] = b_out[g].req;
      assign b_oadd[g] = b_out[g].add;
   end

   hci_core_mux_tracked #(.NB_IN_CHAN(5), .NB_OUT_CHAN(2), .RESP_DEPTH(4), .MAX_WAIT(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .in(b_in), .out(b_out), .err_o(err_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_req = '0; a_ognt = '0; a_orv = '0; a_ordata[0] = '0; a_ordata[1] = '0;
      b_req = '0; b_ognt = '0; b_orv = '0;
      clear_a = 1'b0; clear_b = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (a_oreq !== 2'b00) begin errors++; $display("FAIL reset_a_oreq got %b exp 00", a_oreq); end
      checks++; if (a_gnt !== 4'b0000 || a_rv !== 4'b0000) begin errors++; $display("FAIL reset_a_gnt_rv got %b/%b exp 0000/0000", a_gnt, a_rv); end
      checks++; if (b_oreq !== 2'b00 || b_gnt !== 5'b00000) begin errors++; $display("FAIL reset_b got %b/%b exp 00/00000", b_oreq, b_gnt); end
      checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", err_a, err_b); end
      tick();
   endtask

   // in0 and in2 share output 0; grants alternate, latency-1 responses follow.
   task automatic test_round_robin();
      logic [3:0]  exp_gnt [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
      logic [31:0] exp_add [4] = '{32'h100, 32'h300, 32'h100, 32'h300};
      logic [3:0]  exp_rv  [5] = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
      for (int c = 0; c < 5; c++) begin
         a_req       = (c < 4) ? 4'b0101 : 4'b0000;
         a_ognt[0]   = (c < 4);
         a_orv[0]    = (c > 0);
         a_ordata[0] = 32'hA000 + 32'(c);
         #1;
         checks++; if (a_gnt !== exp_gnt[c]) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", c, a_gnt, exp_gnt[c]); end
         if (c < 4) begin
            checks++; if (a_oadd[0] !== exp_add[c]) begin errors++; $display("FAIL rr_add c%0d got %h exp %h", c, a_oadd[0], exp_add[c]); end
         end
         checks++; if (a_rv !== exp_rv[c]) begin errors++; $display("FAIL rr_rvalid c%0d got %b exp %b", c, a_rv, exp_rv[c]); end
         if (c > 0) begin
            // The responder tags data with the cycle; route it to the in-order owner only.
            checks++;
            if ((exp_rv[c][0] && (a_rdata[0] !== 32'hA000 + 32'(c) || a_rdata[2] !== 32'h0)) ||
                (exp_rv[c][2] && (a_rdata[2] !== 32'hA000 + 32'(c) || a_rdata[0] !== 32'h0))) begin
               errors++; $display("FAIL rr_rdata c%0d got %h/%h", c, a_rdata[0], a_rdata[2]);
            end
         end
         if (c == 1) begin
            checks++; if (a_ropc[0] !== 1'b1 || a_ropc[2] !== 1'b0) begin errors++; $display("FAIL rr_ropc got %b%b exp 10", a_ropc[0], a_ropc[2]); end
         end
         tick();
      end
      a_orv = '0;
      #1;
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", err_a); end
   endtask

   // in1 alone on output 1, latency-3 responses, two-deep tracking.
   task automatic test_backpressure();
      logic exp_req [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic rv_tab  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 10; c++) begin
         a_req       = (c < 9) ? 4'b0010 : 4'b0000;
         a_ognt[1]   = (c < 9);
         a_orv[1]    = rv_tab[c];
         a_ordata[1] = 32'hB000 + 32'(c);
         #1;
         checks++; if (a_oreq[1] !== exp_req[c]) begin errors++; $display("FAIL bp_oreq c%0d got %b exp %b", c, a_oreq[1], exp_req[c]); end
         checks++; if (a_gnt !== {2'b00, exp_req[c], 1'b0}) begin errors++; $display("FAIL bp_gnt c%0d got %b exp %b", c, a_gnt, {2'b00, exp_req[c], 1'b0}); end
         checks++; if (a_rv !== {2'b00, rv_tab[c], 1'b0}) begin errors++; $display("FAIL bp_rvalid c%0d got %b exp %b", c, a_rv, {2'b00, rv_tab[c], 1'b0}); end
         if (rv_tab[c]) begin
            checks++; if (a_rdata[1] !== 32'hB000 + 32'(c)) begin errors++; $display("FAIL bp_rdata c%0d got %h exp %h", c, a_rdata[1], 32'hB000 + 32'(c)); end
         end
         tick();
      end
      idle_inputs();
      #1;
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL bp_err got %b exp 0", err_a); end
   endtask

   // Stray response on output 1 with nothing outstanding.
   task automatic test_err();
      a_orv[1] = 1'b1; a_ordata[1] = 32'hEEEE;
      #1;
      checks++; if (a_rv !== 4'b0000) begin errors++; $display("FAIL err_rvalid got %b exp 0000", a_rv); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err_a); end
      tick();
      a_orv = '0;
      #1;
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_a); end
      tick(); tick();
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_a); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_rst got %b exp 0", err_a); end
   endtask

   // Two outstanding on output 0 (ptr left at 1), then a soft clear.
   task automatic test_clear();
      a_req = 4'b0001; a_ognt[0] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (a_gnt !== 4'b0001) begin errors++; $display("FAIL clr_gnt c%0d got %b exp 0001", c, a_gnt); end
         tick();
      end
      #1;
      checks++; if (a_oreq[0] !== 1'b0 || a_gnt !== 4'b0000) begin errors++; $display("FAIL clr_full got %b/%b exp 0/0000", a_oreq[0], a_gnt); end
      clear_a = 1'b1;
      tick();
      clear_a = 1'b0; a_req = 4'b0101; a_ognt[0] = 1'b0; a_orv[0] = 1'b1;
      #1;
      checks++; if (a_oreq[0] !== 1'b1) begin errors++; $display("FAIL clr_empty got %b exp 1", a_oreq[0]); end
      checks++; if (a_oadd[0] !== 32'h100) begin errors++; $display("FAIL clr_ptr got %h exp 00000100", a_oadd[0]); end
      checks++; if (a_rv !== 4'b0000) begin errors++; $display("FAIL clr_rvalid got %b exp 0000", a_rv); end
      tick();
      idle_inputs();
      #1;
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL clr_err got %b exp 1", err_a); end
   endtask

   // Five inputs, two outputs of different group size rotating independently.
   task automatic test_rotation();
      logic [4:0] exp_gnt [6] = '{5'b00011, 5'b01100, 5'b10010, 5'b01001, 5'b00110, 5'b11000};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         b_req = 5'b11111; b_ognt = 2'b11; b_orv = (c > 0) ? 2'b11 : 2'b00;
         #1;
         checks++; if (b_gnt !== exp_gnt[c]) begin errors++; $display("FAIL rot_gnt c%0d got %b exp %b", c, b_gnt, exp_gnt[c]); end
         tick();
      end
      b_req = '0; b_ognt = '0; b_orv = 2'b11;
      #1;
      checks++; if (b_rv !== 5'b11000) begin errors++; $display("FAIL rot_drain got %b exp 11000", b_rv); end
      tick();
      b_orv = '0;
      #1;
      checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL rot_err got %b exp 0", err_b); end
   endtask

   // in0, in2, in4 on output 0 with gnt toggling; urgency overrides the pointer.
   task automatic test_starvation();
      logic [4:0]  exp_gnt [5] = '{5'b00001, 5'b00000, 5'b00100, 5'b00000, 5'b00001};
      logic [31:0] exp_add [5] = '{32'h100, 32'h300, 32'h300, 32'h100, 32'h100};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         b_req = 5'b10101; b_ognt = {1'b0, (c % 2 == 0)};
         #1;
         checks++; if (b_gnt !== exp_gnt[c]) begin errors++; $display("FAIL starve_gnt c%0d got %b exp %b", c, b_gnt, exp_gnt[c]); end
         checks++; if (b_oadd[0] !== exp_add[c]) begin errors++; $display("FAIL starve_add c%0d got %h exp %h", c, b_oadd[0], exp_add[c]); end
         checks++; if (b_oreq[0] !== 1'b1) begin errors++; $display("FAIL starve_oreq c%0d got %b exp 1", c, b_oreq[0]); end
         tick();
      end
      do_reset();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_round_robin();
      test_backpressure();
      test_err();
      test_clear();
      test_rotation();
      test_starvation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
